hex_entry_display: RTL and testbench
====================================

# hex_entry_display

Parametrised front-panel block that generalises the board's switch-entry register and 7-segment decoders into one unit. It captures a WIDTH-bit word one byte at a time from 8 switches, using an edge-detected write key and a byte pointer. It drives WIDTH/4 active-low hex digits showing either the captured word or a datapath word, with optional leading-zero blanking. It sits between the board pins and the CPU top level: the captured word feeds the CPU instruction input, and the CPU result feeds the display.

## Interface
Parameters:
- WIDTH, 16, captured/displayed word width; must be a multiple of 8 and at least 8.
- Derived: NBYTES = WIDTH/8, DIGITS = WIDTH/4, PW = max(1, ceil(log2(NBYTES))).

Ports:
- clk, input, 1, single clock. All state updates on its rising edge.
- reset, input, 1, synchronous, active-high.
- sw, input, 8, byte value to write.
- wr, input, 1, write key (level). A 0→1 transition writes `sw` into the byte at `ptr`.
- nxt, input, 1, advance key (level). A 0→1 transition increments `ptr`.
- mode, input, 1, display source: 0 = `ir`, 1 = `data_in`.
- blank_lz, input, 1, 1 = blank leading zero digits.
- data_in, input, WIDTH, datapath word to display when `mode`=1.
- ir, output, WIDTH, captured word (registered).
- ptr, output, PW, current byte index (registered).
- leds, output, 8, `ir` byte at `ptr` (combinational from registers).
- hex, output, 7*DIGITS, digit k at bits [7k+6:7k]; bit 0 = top segment, bits 1–5 clockwise, bit 6 = middle; segment lit when bit is 0.

## Operation
- Edge detect:
  - Registers `wr_q` and `nxt_q` hold the previous-cycle `wr` and `nxt`.
  - `wr_rise = wr & ~wr_q`; `nxt_rise = nxt & ~nxt_q`.
  - Holding a key produces exactly one event.
- Write: on `wr_rise`, `ir[8*ptr+7 : 8*ptr] <= sw`. Other bytes hold.
- Pointer:
  - On `nxt_rise`, `ptr <= ptr+1`, wrapping from NBYTES-1 to 0.
  - With NBYTES=1, `ptr` stays 0.
- Simultaneous `wr_rise` and `nxt_rise`: the write uses the pre-increment `ptr`, and `ptr` increments in the same cycle.
- Display source: `v = mode ? data_in : ir`, sampled each cycle.
- Decode of each nibble (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Blanking:
  - With `blank_lz`=1, digit k (k≥1) is 1111111 when nibbles k through DIGITS-1 of `v` are all zero.
  - Digit 0 is never blanked, so `v`=0 shows a single "0".
- `hex` is registered: it is computed from `v` and `blank_lz` of the current cycle and loaded every clock.
- Reset (synchronous, takes priority over all events in the same cycle):
  - `ir`=0, `ptr`=0.
  - `wr_q`=1 and `nxt_q`=1, so a key held through reset release produces no event.
  - `hex` = all ones (every digit dark).
  - `leds` = 0, as a consequence of `ir`=0.

## Timing
- `wr` first sampled high at edge t, with `wr_q`=0: `ir` is updated at edge t, so `leds` and `ir` show the new byte after edge t. `hex` with `mode`=0 reflects it after edge t+1.
- `nxt` rise sampled at edge t: `ptr` and `leds` change after edge t.
- A `data_in` change is visible on `hex` one clock later. `mode` and `blank_lz` changes also take effect one clock later.
- Minimum key event rate: one event per 2 cycles (a key must be seen low for ≥1 cycle between events).
- Reset asserted mid-entry discards all partial bytes. The first clock with `reset`=0 resumes normal operation, and `hex` shows the decoded `v` after that clock.

## Test plan
- Reset, then WIDTH=16, `mode`=0, `blank_lz`=0: `hex` all 1111111 during reset; "0000" one clock after release; `ir`=0, `ptr`=0.
- `sw`=0x34, pulse `wr`; pulse `nxt`; `sw`=0x12, pulse `wr`: `ir`=0x1234, `ptr`=1, `leds`=0x12, `hex` digits 3..0 = 1,2,3,4 patterns.
- Hold `wr` high for 10 cycles while changing `sw` 0x34→0x56 after the first cycle: byte written once, value 0x34 kept. Hold `nxt` for 10 cycles: `ptr` advances once. Second `nxt` pulse wraps `ptr` to 0.
- `wr` and `nxt` rise in the same cycle with `ptr`=1, `sw`=0xAB: `ir[15:8]`=0xAB and `ptr`=0.
- `mode`=1, `data_in`=0x00F0, `blank_lz`=1: digits 3,2 dark, digit1=F, digit0=0. Then `data_in`=0: only digit 0 shows "0". Then `blank_lz`=0: "0000".
- WIDTH=32 instance: four writes with `nxt` pulses between them (0x78, 0x56, 0x34, 0x12) give `ir`=0x12345678 and `ptr`=3. Asserting `reset` with `wr` held high: `ir`=0, and no write occurs after release until `wr` goes low then high.

Source files
------------

// File: rtl/hex_entry_display.sv
// Front-panel entry/display unit: builds a WIDTH-bit word byte by byte from
// switches and drives WIDTH/4 active-low 7-segment digits with optional blanking.
module hex_entry_display #(
  parameter int WIDTH = 16,
  localparam int NBYTES = WIDTH / 8,
  localparam int DIGITS = WIDTH / 4,
  localparam int PW = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            sw,
  input  logic                  wr,
  input  logic                  nxt,
  input  logic                  mode,
  input  logic                  blank_lz,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      ir,
  output logic [PW-1:0]         ptr,
  output logic [7:0]            leds,
  output logic [7*DIGITS-1:0]   hex
);

  logic                r_wr_q;
  logic                r_nxt_q;
  logic [WIDTH-1:0]    r_ir;
  logic [PW-1:0]       r_ptr;
  logic [7*DIGITS-1:0] r_hex;
  logic                w_wr_rise;
  logic                w_nxt_rise;
  logic [WIDTH-1:0]    w_v;
  logic [7*DIGITS-1:0] w_hex_next;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0011000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Key history resets high so a key held across reset release is not an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_q  <= 1'b1;
      r_nxt_q <= 1'b1;
    end else begin
      r_wr_q  <= wr;
      r_nxt_q <= nxt;
    end
  end

  assign w_wr_rise  = wr & ~r_wr_q;
  assign w_nxt_rise = nxt & ~r_nxt_q;

  // The write selects its byte with the pre-increment pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir <= '0;
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        if (w_wr_rise && (r_ptr == PW'(i))) r_ir[8*i +: 8] <= sw;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_nxt_rise) begin
      r_ptr <= (r_ptr == PW'(NBYTES - 1)) ? '0 : r_ptr + PW'(1);
    end
  end

  assign w_v = mode ? data_in : r_ir;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign w_hex_next[6:0] = seg7(w_v[3:0]);
      end else begin : g_upper
        logic w_zero_above;
        assign w_zero_above = (w_v[WIDTH-1:4*gi] == '0);
        assign w_hex_next[7*gi +: 7] = (blank_lz && w_zero_above) ? 7'h7F
                                                                  : seg7(w_v[4*gi +: 4]);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) r_hex <= '1;
    else       r_hex <= w_hex_next;
  end

  assign ir   = r_ir;
  assign ptr  = r_ptr;
  assign leds = r_ir[8*r_ptr +: 8];
  assign hex  = r_hex;

endmodule

// File: tb/tb_hex_entry_display.sv
// Bench for hex_entry_display: 16- and 32-bit instances driven in parallel and
// compared with a behavioural model of byte entry and digit display.
module tb_hex_entry_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sw;
  logic        wr, nxt, mode, blank_lz;
  logic [31:0] data_in;

  logic [15:0] ir16;
  logic [0:0]  ptr16;
  logic [7:0]  leds16;
  logic [27:0] hex16;
  logic [31:0] ir32;
  logic [1:0]  ptr32;
  logic [7:0]  leds32;
  logic [55:0] hex32;

  always #5 clk = ~clk;

  hex_entry_display #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .sw(sw), .wr(wr), .nxt(nxt), .mode(mode),
    .blank_lz(blank_lz), .data_in(data_in[15:0]),
    .ir(ir16), .ptr(ptr16), .leds(leds16), .hex(hex16)
  );

  hex_entry_display #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .sw(sw), .wr(wr), .nxt(nxt), .mode(mode),
    .blank_lz(blank_lz), .data_in(data_in),
    .ir(ir32), .ptr(ptr32), .leds(leds32), .hex(hex32)
  );

  logic [31:0] o_ir [2];
  logic [31:0] o_ptr [2];
  logic [7:0]  o_leds [2];
  logic [55:0] o_hex [2];
  assign o_ir[0]   = {16'b0, ir16};
  assign o_ir[1]   = ir32;
  assign o_ptr[0]  = {31'b0, ptr16};
  assign o_ptr[1]  = {30'b0, ptr32};
  assign o_leds[0] = leds16;
  assign o_leds[1] = leds32;
  assign o_hex[0]  = {28'b0, hex16};
  assign o_hex[1]  = hex32;

  // Behavioural model
  logic [6:0]  seg_tab [16];
  logic [31:0] m_ir [2];
  logic [31:0] m_ptr [2];
  logic [55:0] m_hex [2];
  logic        m_wrq, m_nxtq;
  int          checks = 0;
  int          errors = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, SF = 7'b0001110, SD = 7'h7F;

  function automatic int digits_of(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic logic [55:0] enc(input logic [31:0] v, input int digits, input logic blank);
    logic [55:0] r;
    r = '0;
    for (int k = 0; k < digits; k++) begin
      if (blank && k > 0 && (v >> (4 * k)) == 0) r[7*k +: 7] = 7'h7F;
      else r[7*k +: 7] = seg_tab[(v >> (4 * k)) & 32'hF];
    end
    return r;
  endfunction

  task automatic model_edge();
    logic [31:0] v;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_ir[i]  = 0;
        m_ptr[i] = 0;
        m_hex[i] = (56'b1 << (7 * digits_of(i))) - 56'b1;
      end else begin
        v = mode ? (data_in & ((i == 0) ? 32'hFFFF : 32'hFFFF_FFFF)) : m_ir[i];
        m_hex[i] = enc(v, digits_of(i), blank_lz);
        if (wr && !m_wrq)
          m_ir[i] = (m_ir[i] & ~(32'hFF << (8 * m_ptr[i]))) | ({24'b0, sw} << (8 * m_ptr[i]));
        if (nxt && !m_nxtq)
          m_ptr[i] = (m_ptr[i] + 1) % (digits_of(i) / 2);
      end
    end
    m_wrq  = reset ? 1'b1 : wr;
    m_nxtq = reset ? 1'b1 : nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; sw = 0; wr = 0; nxt = 0; mode = 0; blank_lz = 0; data_in = 0;
    step(); step(); step();
    checks += 3;
    if (hex16 !== 28'hFFF_FFFF) begin errors++; $display("FAIL reset_hex16: got %h expected fffffff", hex16); end
    if (hex32 !== 56'hFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL reset_hex32: got %h expected all ones", hex32); end
    if (ir16 !== 16'h0 || ptr16 !== 1'b0 || leds16 !== 8'h0) begin
      errors++; $display("FAIL reset_state16: ir %h ptr %0d leds %h, expected 0", ir16, ptr16, leds16);
    end
    reset = 0;
    step();
    checks++;
    if (hex16 !== {S0, S0, S0, S0}) begin errors++; $display("FAIL release_hex16: got %h expected %h", hex16, {S0, S0, S0, S0}); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_hex[i] !== m_hex[i]) begin errors++; $display("FAIL release_hex inst%0d: got %h expected %h", i, o_hex[i], m_hex[i]); end
    end
    $display("reset: hex16=%h ir16=%h ptr16=%0d", hex16, ir16, ptr16);
  endtask

  task automatic test_entry();
    sw = 8'h34; wr = 1; step(); wr = 0; step();
    nxt = 1; step(); nxt = 0; step();
    sw = 8'h12; wr = 1; step(); wr = 0; step();
    checks += 4;
    if (ir16 !== 16'h1234) begin errors++; $display("FAIL entry_ir: got %h expected 1234", ir16); end
    if (ptr16 !== 1'b1) begin errors++; $display("FAIL entry_ptr: got %0d expected 1", ptr16); end
    if (leds16 !== 8'h12) begin errors++; $display("FAIL entry_leds: got %h expected 12", leds16); end
    if (hex16 !== {S1, S2, S3, S4}) begin errors++; $display("FAIL entry_hex: got %h expected %h", hex16, {S1, S2, S3, S4}); end
    $display("entry: ir16=%h ptr16=%0d leds16=%h hex16=%h", ir16, ptr16, leds16, hex16);
  endtask

  task automatic test_hold_keys();
    sw = 8'h34; wr = 1; step();
    sw = 8'h56;
    repeat (9) step();
    wr = 0; step();
    checks++;
    if (ir16 !== 16'h3434) begin errors++; $display("FAIL hold_wr: got %h expected 3434", ir16); end
    nxt = 1;
    repeat (10) step();
    nxt = 0; step();
    checks++;
    if (ptr16 !== 1'b0 || ptr32 !== 2'd2) begin
      errors++; $display("FAIL hold_nxt: got ptr16 %0d ptr32 %0d expected 0 and 2", ptr16, ptr32);
    end
    nxt = 1; step(); nxt = 0; step();
    nxt = 1; step(); nxt = 0; step();
    checks++;
    if (ptr16 !== 1'b0 || ptr32 !== 2'd0) begin
      errors++; $display("FAIL wrap_nxt: got ptr16 %0d ptr32 %0d expected 0 and 0", ptr16, ptr32);
    end
    $display("hold: ir16=%h ptr16=%0d ptr32=%0d", ir16, ptr16, ptr32);
  endtask

  task automatic test_simultaneous();
    nxt = 1; step(); nxt = 0; step();
    sw = 8'hAB; wr = 1; nxt = 1; step();
    wr = 0; nxt = 0; step();
    checks += 2;
    if (ir16[15:8] !== 8'hAB) begin errors++; $display("FAIL simul_ir: got %h expected ab", ir16[15:8]); end
    if (ptr16 !== 1'b0) begin errors++; $display("FAIL simul_ptr: got %0d expected 0", ptr16); end
    for (int i = 0; i < 2; i++) begin
      checks += 2;
      if (o_ir[i] !== m_ir[i]) begin errors++; $display("FAIL simul_ir_model inst%0d: got %h expected %h", i, o_ir[i], m_ir[i]); end
      if (o_ptr[i] !== m_ptr[i]) begin errors++; $display("FAIL simul_ptr_model inst%0d: got %0d expected %0d", i, o_ptr[i], m_ptr[i]); end
    end
    $display("simultaneous: ir16=%h ptr16=%0d", ir16, ptr16);
  endtask

  task automatic test_display();
    mode = 1; data_in = 32'h0000_00F0; blank_lz = 1; step();
    checks++;
    if (hex16 !== {SD, SD, SF, S0}) begin errors++; $display("FAIL blank_f0: got %h expected %h", hex16, {SD, SD, SF, S0}); end
    data_in = 0; step();
    checks++;
    if (hex16 !== {SD, SD, SD, S0}) begin errors++; $display("FAIL blank_zero: got %h expected %h", hex16, {SD, SD, SD, S0}); end
    blank_lz = 0; step();
    checks++;
    if (hex16 !== {S0, S0, S0, S0}) begin errors++; $display("FAIL noblank_zero: got %h expected %h", hex16, {S0, S0, S0, S0}); end
    mode = 0;
    $display("display: hex16=%h hex32=%h", hex16, hex32);
  endtask

  task automatic test_w32();
    logic [7:0] bytes [4];
    bytes[0] = 8'h78; bytes[1] = 8'h56; bytes[2] = 8'h34; bytes[3] = 8'h12;
    reset = 1; step(); reset = 0; step();
    for (int b = 0; b < 4; b++) begin
      sw = bytes[b]; wr = 1; step(); wr = 0; step();
      if (b < 3) begin nxt = 1; step(); nxt = 0; step(); end
    end
    checks += 2;
    if (ir32 !== 32'h1234_5678) begin errors++; $display("FAIL w32_ir: got %h expected 12345678", ir32); end
    if (ptr32 !== 2'd3) begin errors++; $display("FAIL w32_ptr: got %0d expected 3", ptr32); end
    wr = 1; reset = 1; step(); step();
    reset = 0; step(); step();
    checks++;
    if (ir32 !== 32'h0 || ptr32 !== 2'd0) begin
      errors++; $display("FAIL reset_held_wr: got ir %h ptr %0d expected 0", ir32, ptr32);
    end
    wr = 0; step();
    sw = 8'hAA; wr = 1; step(); wr = 0; step();
    checks++;
    if (ir32 !== 32'h0000_00AA) begin errors++; $display("FAIL rewrite_after_reset: got %h expected 000000aa", ir32); end
    $display("w32: ir32=%h ptr32=%0d", ir32, ptr32);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 49) == 0);
      sw       = 8'($urandom);
      wr       = 1'($urandom);
      nxt      = 1'($urandom);
      mode     = 1'($urandom);
      blank_lz = 1'($urandom);
      data_in  = $urandom >> $urandom_range(0, 31);
      step();
      for (int i = 0; i < 2; i++) begin
        checks += 4;
        if (o_ir[i] !== m_ir[i]) begin errors++; $display("FAIL rand_ir inst%0d cyc%0d: got %h expected %h", i, n, o_ir[i], m_ir[i]); end
        if (o_ptr[i] !== m_ptr[i]) begin errors++; $display("FAIL rand_ptr inst%0d cyc%0d: got %0d expected %0d", i, n, o_ptr[i], m_ptr[i]); end
        if (o_leds[i] !== 8'(m_ir[i] >> (8 * m_ptr[i]))) begin
          errors++; $display("FAIL rand_leds inst%0d cyc%0d: got %h expected %h", i, n, o_leds[i], 8'(m_ir[i] >> (8 * m_ptr[i])));
        end
        if (o_hex[i] !== m_hex[i]) begin errors++; $display("FAIL rand_hex inst%0d cyc%0d: got %h expected %h", i, n, o_hex[i], m_hex[i]); end
      end
    end
    reset = 0; wr = 0; nxt = 0;
    $display("random: 600 cycles, ir32=%h hex32=%h", ir32, hex32);
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    m_wrq = 1; m_nxtq = 1;
    for (int i = 0; i < 2; i++) begin m_ir[i] = 0; m_ptr[i] = 0; m_hex[i] = 0; end
    test_reset();
    test_entry();
    test_hold_keys();
    test_simultaneous();
    test_display();
    test_w32();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
